// File: rtl/fpalu_pkg.sv
// fpalu_pkg: opcodes, word geometry, in-flight tag type and word pack/unpack helpers
//   shared by the FPALU issue arbiter and its tag pipe.
package fpalu_pkg;
   localparam logic [1:0] OP_MUL16I = 2'b10;
   localparam logic [1:0] OP_ADD29I = 2'b11;
   localparam int EXP_W  = 6;
   localparam int MAN_W  = 22;
   localparam int WORD_W = 1 + EXP_W + MAN_W;
   typedef struct packed {
      logic valid;
      logic id;
      logic err;
   } tag_t;
   typedef struct packed {
      logic             sgn;
      logic [EXP_W-1:0] exp;
      logic [MAN_W-1:0] man_dn;
   } fp_word_t;
   function automatic logic [WORD_W-1:0] fp_pack(input logic sgn, input logic [EXP_W-1:0] exp,
                                                 input logic [MAN_W-1:0] man_dn);
      return {sgn, exp, man_dn};
   endfunction
   function automatic fp_word_t fp_unpack(input logic [WORD_W-1:0] w);
      return fp_word_t'(w);
   endfunction
   // Anything outside {ADD29i, MUL16i} (i.e. 2'b0x) is reserved.
   function automatic logic op_reserved(input logic [1:0] op);
      return ~op[1];
   endfunction
endpackage

// File: rtl/fpalu_tag_pipe.sv
// fpalu_tag_pipe: DEPTH-stage shift register of W-bit tags with async active-low reset.
//   d       in   W  tag entering stage 0
//   q       out  W  tag leaving the last stage
//   any_msb out  1  OR of every stage's MSB (the tag valid bit)
module fpalu_tag_pipe #(
   parameter int DEPTH = 2,
   parameter int W     = 3
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] d,
   output logic [W-1:0] q,
   output logic         any_msb
);
   logic [W-1:0] sr [DEPTH];
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) sr[i] <= '0;
      end else begin
         sr[0] <= d;
         for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
      end
   end
   always_comb begin
      any_msb = 1'b0;
      for (int i = 0; i < DEPTH; i++) any_msb = any_msb | sr[i][W-1];
   end
   assign q = sr[DEPTH-1];
endmodule

// File: rtl/fpalu_issue_arb.sv
// fpalu_issue_arb: round-robin issue of two requesters onto one FPALU, with result routing.
//   req0_*/req1_*   requester side: valid/op/a/b in, ready out (accept this cycle)
//   resp0_*/resp1_* one-cycle valid/err pulse per requester; resp_y shared result word
//   alu_*           registered FPALU input bus out, alu_y_* FPALU result in
//   busy            any op in issue reg, tag pipe or output stage
//   cnt0/cnt1       accepted-op counters per requester, wrap at 2^CNT_W
module fpalu_issue_arb
   import fpalu_pkg::*;
#(
   parameter int ALU_LAT = 1,
   parameter int CNT_W   = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic [1:0]        req0_op,
   input  logic [28:0]       req0_a,
   input  logic [28:0]       req0_b,
   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic [1:0]        req1_op,
   input  logic [28:0]       req1_a,
   input  logic [28:0]       req1_b,
   output logic              resp0_valid,
   output logic              resp0_err,
   output logic              resp1_valid,
   output logic              resp1_err,
   output logic [28:0]       resp_y,
   output logic [1:0]        alu_opcode,
   output logic              alu_a_sgn,
   output logic [5:0]        alu_a_exp,
   output logic [21:0]       alu_a_man_dn,
   output logic              alu_b_sgn,
   output logic [5:0]        alu_b_exp,
   output logic [21:0]       alu_b_man_dn,
   input  logic              alu_y_sgn,
   input  logic [5:0]        alu_y_exp,
   input  logic [21:0]       alu_y_man_dn,
   output logic              busy,
   output logic [CNT_W-1:0]  cnt0,
   output logic [CNT_W-1:0]  cnt1
);
   logic              rr_ptr, gnt0, gnt1, acc, rsv, iss_v, pipe_busy;
   logic [1:0]        sel_op, iss_op;
   logic [WORD_W-1:0] sel_a, sel_b, iss_a, iss_b, res;
   tag_t              in_tag, tail_tag, out_tag;
   fp_word_t          ua, ub;
   // rr_ptr names the side that wins a tie; a lone requester always wins.
   assign gnt0   = req0_valid & (~req1_valid | ~rr_ptr);
   assign gnt1   = req1_valid & (~req0_valid | rr_ptr);
   assign acc    = gnt0 | gnt1;
   assign sel_op = gnt1 ? req1_op : req0_op;
   assign sel_a  = gnt1 ? req1_a : req0_a;
   assign sel_b  = gnt1 ? req1_b : req0_b;
   assign rsv    = op_reserved(sel_op);
   assign in_tag = {acc, gnt1, acc & rsv};
   fpalu_tag_pipe #(.DEPTH(ALU_LAT + 1), .W($bits(tag_t))) u_tag_pipe (
      .clk     (clk),
      .rst_n   (rst_n),
      .d       (in_tag),
      .q       (tail_tag),
      .any_msb (pipe_busy)
   );
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr  <= 1'b0;
         iss_v   <= 1'b0;
         iss_op  <= '0;
         iss_a   <= '0;
         iss_b   <= '0;
         res     <= '0;
         out_tag <= '0;
         cnt0    <= '0;
         cnt1    <= '0;
      end else begin
         // Pointer moves to the loser after a grant: granting 0 makes 1 the next tie winner.
         rr_ptr  <= acc ? gnt0 : rr_ptr;
         iss_v   <= acc & ~rsv;
         // Reserved ops skip the issue reg so the ALU bus keeps its previous operands.
         if (acc && !rsv) begin
            iss_op <= sel_op;
            iss_a  <= sel_a;
            iss_b  <= sel_b;
         end
         out_tag <= tail_tag;
         if (tail_tag.valid) res <= tail_tag.err ? '0 : fp_pack(alu_y_sgn, alu_y_exp, alu_y_man_dn);
         cnt0    <= cnt0 + {{(CNT_W-1){1'b0}}, gnt0};
         cnt1    <= cnt1 + {{(CNT_W-1){1'b0}}, gnt1};
      end
   end
   assign ua           = fp_unpack(iss_a);
   assign ub           = fp_unpack(iss_b);
   assign alu_opcode   = iss_op;
   assign alu_a_sgn    = ua.sgn;
   assign alu_a_exp    = ua.exp;
   assign alu_a_man_dn = ua.man_dn;
   assign alu_b_sgn    = ub.sgn;
   assign alu_b_exp    = ub.exp;
   assign alu_b_man_dn = ub.man_dn;
   assign req0_ready   = gnt0;
   assign req1_ready   = gnt1;
   assign resp0_valid  = out_tag.valid & ~out_tag.id;
   assign resp1_valid  = out_tag.valid & out_tag.id;
   assign resp0_err    = resp0_valid & out_tag.err;
   assign resp1_err    = resp1_valid & out_tag.err;
   assign resp_y       = res;
   assign busy         = iss_v | pipe_busy | out_tag.valid;
endmodule
